gc_dram_refresh_ctrl: RTL and testbench
=======================================

Name: gc_dram_refresh_ctrl

Overview:
- Controller in front of the 128x64 gain-cell DRAM macro.
- Accepts user read/write requests and issues them to the macro's separate read and write ports.
- Schedules round-robin refresh so every row is rewritten within the macro's 5000-cycle retention window.
- A per-row "fresh" bitmap lets rows rewritten by user writes skip their next scheduled refresh.

Parameters:
- ROWS, 128, number of macro rows; power of two.
- AW, 7, row address width; equals log2(ROWS).
- DW, 64, data width.
- REFRESH_INTERVAL, 16, cycles between refresh ticks; must satisfy 4 ≤ REFRESH_INTERVAL and 2*ROWS*REFRESH_INTERVAL < 4999.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  user request valid.
- req_ready  out  1  controller accepts request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  row address.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  read data valid, one-cycle pulse.
- rsp_rdata  out  DW  read data.
- mem_re  out  1  macro read enable.
- mem_we  out  1  macro write enable.
- mem_raddr  out  AW  macro read address.
- mem_waddr  out  AW  macro write address.
- mem_wdata  out  DW  macro write data.
- mem_rd  in  DW  macro read data; valid the cycle after mem_re.
- refresh_busy  out  1  controller is in REF_RD or REF_WB.
- refresh_count  out  16  refreshes performed; wraps.
- skip_count  out  16  refreshes skipped; wraps.

Behaviour:
- Reset values:
  - FSM=IDLE, timer=0, ptr=0, fresh bitmap all 0, pending=0, both counters 0.
  - mem_re=0, mem_we=0, rsp_valid=0, req_ready=0 during reset.
  - Addresses and data outputs are 0.
- Reset mid-refresh abandons the operation; no write-back is issued.
- Timer: counts 0..REFRESH_INTERVAL-1 and wraps. The wrap cycle is a "tick".
- On tick:
  - If fresh[ptr]=1, or an accepted user write targets ptr in the same cycle: clear fresh[ptr], ptr←ptr+1 (wraps 127→0), skip_count++. No macro access and no pending.
  - Otherwise pending←1.
- FSM states: IDLE, REF_RD, REF_WB.
  - IDLE, pending=0: req_ready=1. An accepted request is issued combinationally the same cycle.
    - Write: mem_we=1, mem_waddr=req_addr, mem_wdata=req_wdata; set fresh[req_addr].
    - Read: mem_re=1, mem_raddr=req_addr.
  - IDLE, pending=1: req_ready=0. Go to REF_RD. Refresh has priority over new requests.
  - REF_RD: mem_re=1, mem_raddr=ptr, req_ready=0. Go to REF_WB.
  - REF_WB: mem_we=1, mem_waddr=ptr, mem_wdata=mem_rd, req_ready=0. Then:
    - clear fresh[ptr], ptr++, refresh_count++, pending←0;
    - go to IDLE.
- Read latency: read accepted in cycle N gives rsp_valid=1 and rsp_rdata=mem_rd in cycle N+1.
  - Back-to-back reads sustain one per cycle.
  - A response owed from IDLE cycle N is still delivered in N+1 even if N+1 is REF_RD.
- mem_re and mem_we are never asserted in the same cycle. This avoids the macro's X result for a same-address collision.
- Refresh latency: request stall is at most 2 cycles per tick; pending is serviced the cycle after it is set.
- Worst-case retention:
  - A row written just after its refresh visit is skipped once, then refreshed.
  - Its age stays below 2*ROWS*REFRESH_INTERVAL = 4096 cycles for the defaults.
- A user write to a row whose refresh is pending still proceeds if accepted before the pending stall. The later refresh rewrites the same data.
- When idle, mem_raddr and mem_waddr hold their last values; re and we are 0.

Test Plan:
- Reset, then idle 20 cycles → first tick at cycle 15.
  - REF_RD on row 0 at cycle 16, REF_WB on row 0 at cycle 17.
  - refresh_count=1, ptr=1, req_ready low exactly in cycles 16-17.
- Write 0xDEADBEEF_CAFEF00D to row 5, then read row 5 → rsp_valid one cycle after read acceptance, rsp_rdata=0xDEADBEEF_CAFEF00D.
- Write row 0 before the first tick → tick at cycle 15 skips row 0: skip_count=1, refresh_count=0, no mem_re. The next tick refreshes row 1.
- Write all 128 rows with distinct data, idle 20000 cycles, read all rows → every value intact (no X), refresh_count plus skip_count consistent with elapsed ticks.
- Continuous reads while a tick fires → req_ready drops for exactly 2 cycles, the in-flight response is still delivered, and mem_re/mem_we are never both 1.
- Assert rst during REF_RD → next cycle mem_re=0 and mem_we=0, FSM=IDLE, ptr=0, both counters 0.

Source files
------------

// File: rtl/gc_dram_refresh_ctrl_if.sv
// User request/response bus for the gain-cell DRAM refresh controller.
// The master side issues requests; the slave side is the controller.
interface gc_dram_refresh_ctrl_if #(
  parameter int AW = 7,
  parameter int DW = 64
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata
  );
endinterface

// File: rtl/gc_dram_refresh_ctrl.sv
// Gain-cell DRAM controller: forwards user reads/writes to the macro ports
// and interleaves round-robin refresh, skipping rows freshly user-written.
module gc_dram_refresh_ctrl #(
  parameter int ROWS             = 128,
  parameter int AW               = 7,
  parameter int DW               = 64,
  parameter int REFRESH_INTERVAL = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  gc_dram_refresh_ctrl_if.slave bus,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_raddr,
  output logic [AW-1:0]         mem_waddr,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rd,
  output logic                  refresh_busy,
  output logic [15:0]           refresh_count,
  output logic [15:0]           skip_count
);

  localparam int TW = (REFRESH_INTERVAL > 2) ?
                      $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0] TLAST = TW'(REFRESH_INTERVAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    REF_RD,
    REF_WB
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [ROWS-1:0] fresh_q, fresh_d;
  logic            pending_q, pending_d;
  logic [15:0]     ref_cnt_q, ref_cnt_d;
  logic [15:0]     skip_cnt_q, skip_cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [AW-1:0]   raddr_q, waddr_q;
  logic [DW-1:0]   wdata_q;

  logic            tick;
  logic            ready_c;
  logic            accept;
  logic            skip;
  logic            re_c, we_c;
  logic [AW-1:0]   raddr_c, waddr_c;
  logic [DW-1:0]   wdata_c;

  assign tick    = (timer_q == TLAST);
  assign timer_d = tick ? '0 : timer_q + TW'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    fresh_d     = fresh_q;
    pending_d   = pending_q;
    ref_cnt_d   = ref_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    rsp_valid_d = 1'b0;
    ready_c     = 1'b0;
    accept      = 1'b0;
    skip        = 1'b0;
    re_c        = 1'b0;
    we_c        = 1'b0;
    raddr_c     = raddr_q;
    waddr_c     = waddr_q;
    wdata_c     = wdata_q;

    unique case (state_q)
      IDLE: begin
        ready_c = ~pending_q;
        accept  = bus.req_valid & ready_c;
        if (accept && bus.req_we) begin
          we_c                  = 1'b1;
          waddr_c               = bus.req_addr;
          wdata_c               = bus.req_wdata;
          fresh_d[bus.req_addr] = 1'b1;
        end
        if (accept && !bus.req_we) begin
          re_c        = 1'b1;
          raddr_c     = bus.req_addr;
          rsp_valid_d = 1'b1;
        end
        // Ticks only land here: a refresh takes 2 cycles and the
        // interval is at least 4, so the FSM is always back in IDLE.
        if (tick) begin
          skip = fresh_q[ptr_q] |
                 (accept & bus.req_we & (bus.req_addr == ptr_q));
          if (skip) begin
            fresh_d[ptr_q] = 1'b0;
            ptr_d          = ptr_q + AW'(1);
            skip_cnt_d     = skip_cnt_q + 16'd1;
          end else begin
            pending_d = 1'b1;
          end
        end
        if (pending_d) begin
          state_d = REF_RD;
        end
      end
      REF_RD: begin
        re_c    = 1'b1;
        raddr_c = ptr_q;
        state_d = REF_WB;
      end
      REF_WB: begin
        we_c           = 1'b1;
        waddr_c        = ptr_q;
        wdata_c        = mem_rd;
        fresh_d[ptr_q] = 1'b0;
        ptr_d          = ptr_q + AW'(1);
        ref_cnt_d      = ref_cnt_q + 16'd1;
        pending_d      = 1'b0;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      ptr_q       <= '0;
      fresh_q     <= '0;
      pending_q   <= 1'b0;
      ref_cnt_q   <= '0;
      skip_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ptr_q       <= ptr_d;
      fresh_q     <= fresh_d;
      pending_q   <= pending_d;
      ref_cnt_q   <= ref_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      raddr_q     <= raddr_c;
      waddr_q     <= waddr_c;
      wdata_q     <= wdata_c;
    end
  end

  // Reset forces a quiet macro interface even mid-refresh.
  assign mem_re        = re_c & ~rst;
  assign mem_we        = we_c & ~rst;
  assign mem_raddr     = rst ? '0 : raddr_c;
  assign mem_waddr     = rst ? '0 : waddr_c;
  assign mem_wdata     = rst ? '0 : wdata_c;

  assign bus.req_ready = ready_c & ~rst;
  assign bus.rsp_valid = rsp_valid_q & ~rst;
  assign bus.rsp_rdata = (rsp_valid_q & ~rst) ? mem_rd : '0;

  assign refresh_busy  = (state_q == REF_RD) | (state_q == REF_WB);
  assign refresh_count = ref_cnt_q;
  assign skip_count    = skip_cnt_q;

endmodule

// File: tb/tb_gc_dram_refresh_ctrl.sv
// Directed bench for gc_dram_refresh_ctrl with a behavioural
// gain-cell macro that loses rows older than the retention window.
module tb_gc_dram_refresh_ctrl;
  localparam int AW = 7;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gc_dram_refresh_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  logic          mem_re, mem_we;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rd;
  logic          refresh_busy;
  logic [15:0]   refresh_count, skip_count;

  gc_dram_refresh_ctrl #(
    .ROWS(128), .AW(AW), .DW(DW), .REFRESH_INTERVAL(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .mem_re(mem_re),
    .mem_we(mem_we),
    .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .mem_rd(mem_rd),
    .refresh_busy(refresh_busy),
    .refresh_count(refresh_count),
    .skip_count(skip_count)
  );

  // Macro model: rows older than 4999 cycles read back as X.
  logic [DW-1:0] mem [128];
  int            wtime [128];
  int            cyc_abs = 0;

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i]   = '0;
      wtime[i] = 0;
    end
    mem_rd = '0;
  end

  always @(posedge clk) begin
    cyc_abs <= cyc_abs + 1;
    if (mem_re && mem_we)
      mem_rd <= 'x;
    else if (mem_re)
      mem_rd <= (cyc_abs - wtime[mem_raddr] > 4999) ?
                'x : mem[mem_raddr];
    if (mem_we) begin
      mem[mem_waddr]   <= mem_wdata;
      wtime[mem_waddr] <= cyc_abs;
    end
  end

  int coll = 0;
  always @(negedge clk) begin
    #3;
    if (mem_re === 1'b1 && mem_we === 1'b1) coll++;
  end

  int n_checks = 0;
  int n_errors = 0;
  int c = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic next_cyc();
    @(negedge clk);
    c++;
  endtask

  task automatic run_to(input int n);
    while (c < n) next_cyc();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c = 0;
  endtask

  function automatic logic [63:0] pat(input int r);
    logic [31:0] a, b;
    a = 32'hC0DE0000 | 32'(r);
    b = ~32'(r) ^ 32'h5A5A5A5A;
    return {a, b};
  endfunction

  task automatic issue(input string tag, input logic we,
                       input int addr, input logic [63:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = AW'(addr);
    bus.req_wdata = d;
    #1;
    for (int k = 0; k < 4 && !bus.req_ready; k++) begin
      next_cyc();
      #1;
    end
    if (!bus.req_ready) check({tag, "_timeout"}, 0, 1);
    next_cyc();
    set_idle();
  endtask

  logic [19:0] rdy20;
  logic [23:0] rdy24, vld24;
  int          nre;

  initial begin
    set_idle();
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", bus.req_ready, 0);
    check("rst_re", mem_re, 0);
    check("rst_we", mem_we, 0);
    check("rst_rsp", bus.rsp_valid, 0);
    check("rst_raddr", mem_raddr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_cnts", {refresh_count, skip_count}, 0);
    check("rst_busy", refresh_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    c = 0;

    // First tick at 15, refresh row 0 in 16-17.
    for (int i = 0; i < 20; i++) begin
      #1;
      rdy20[i] = bus.req_ready;
      if (i == 16) begin
        check("A_rd_re", mem_re, 1);
        check("A_rd_addr", mem_raddr, 0);
        check("A_busy", refresh_busy, 1);
      end
      if (i == 17) begin
        check("A_wb_we", mem_we, 1);
        check("A_wb_addr", mem_waddr, 0);
      end
      next_cyc();
    end
    #1;
    check("A_ready_pat", rdy20, 20'hCFFFF);
    check("A_ref_cnt", refresh_count, 1);
    check("A_skip_cnt", skip_count, 0);
    run_to(32);
    #1;
    check("A_ptr1_re", mem_re, 1);
    check("A_ptr1_addr", mem_raddr, 1);

    // Write then read row 5.
    do_reset();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 7'd5;
    bus.req_wdata = 64'hDEADBEEF_CAFEF00D;
    #1;
    check("B_ready", bus.req_ready, 1);
    check("B_we", mem_we, 1);
    check("B_waddr", mem_waddr, 5);
    check("B_wdata", mem_wdata, 64'hDEADBEEF_CAFEF00D);
    next_cyc();
    bus.req_we = 1'b0;
    #1;
    check("B_re", mem_re, 1);
    check("B_raddr", mem_raddr, 5);
    check("B_rsp_early", bus.rsp_valid, 0);
    next_cyc();
    set_idle();
    #1;
    check("B_rsp_valid", bus.rsp_valid, 1);
    check("B_rsp_data", bus.rsp_rdata, 64'hDEADBEEF_CAFEF00D);
    check("B_hold_raddr", mem_raddr, 5);
    check("B_idle_re", mem_re, 0);
    next_cyc();
    #1;
    check("B_rsp_pulse", bus.rsp_valid, 0);

    // Row 0 written before the first tick gets skipped.
    do_reset();
    issue("C_wr", 1'b1, 0, 64'h1111);
    nre = 0;
    while (c <= 20) begin
      #1;
      if (mem_re) nre++;
      next_cyc();
    end
    check("C_no_re", nre, 0);
    check("C_skip_cnt", skip_count, 1);
    check("C_ref_cnt", refresh_count, 0);
    run_to(32);
    #1;
    check("C_row1_re", mem_re, 1);
    check("C_row1_addr", mem_raddr, 1);
    run_to(34);
    #1;
    check("C_ref_cnt2", refresh_count, 1);

    // Fill all rows, idle well past retention, read back.
    do_reset();
    for (int r = 0; r < 128; r++) issue("D_wr", 1'b1, r, pat(r));
    run_to(c + 20000);
    while (c % 16 != 4) next_cyc();
    #1;
    check("D_ticks", 32'(refresh_count) + 32'(skip_count), c / 16);
    check("D_skips", skip_count, 128);
    next_cyc();
    for (int r = 0; r < 128; r++) begin
      issue("D_rd", 1'b0, r, 64'h0);
      #1;
      check("D_rsp_valid", bus.rsp_valid, 1);
      check("D_rsp_data", bus.rsp_rdata, pat(r));
      next_cyc();
    end

    // Continuous reads across a tick.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = AW'(i % 8);
      #1;
      rdy24[i] = bus.req_ready;
      vld24[i] = bus.rsp_valid;
      if (i == 16) begin
        check("E_inflight", bus.rsp_rdata, pat(7));
        check("E_ref_addr", mem_raddr, 0);
      end
      next_cyc();
    end
    set_idle();
    check("E_ready_pat", rdy24, 24'hFCFFFF);
    check("E_valid_pat", vld24, 24'hF9FFFE);

    // Reset in the middle of a refresh.
    do_reset();
    run_to(32);
    #1;
    check("F_pre_re", mem_re, 1);
    check("F_pre_cnt", refresh_count, 1);
    #1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    c = 0;
    #1;
    check("F_re", mem_re, 0);
    check("F_we", mem_we, 0);
    check("F_busy", refresh_busy, 0);
    check("F_cnts", {refresh_count, skip_count}, 0);
    run_to(16);
    #1;
    check("F_ptr0_re", mem_re, 1);
    check("F_ptr0_addr", mem_raddr, 0);
    next_cyc();

    check("no_collision", coll, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
